// File: rtl/datam_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: opcodes, funct3
// codes, exception codes and FSM encoding.
package datam_lsu_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // An illegal width outranks misalignment: the access size itself is meaningless.
   function automatic logic [1:0] exc_code(input logic misalign, input logic illegal);
      if (illegal)       return EXC_ILLEGAL;
      else if (misalign) return EXC_MISALIGN;
      else               return EXC_NONE;
   endfunction

endpackage

// File: rtl/datam_lsu_align.sv
// Combinational lane steering for stores, extraction/extension for loads,
// and width/alignment checking of a memory access.
module datam_lsu_align
   import datam_lsu_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int BE_W  = XLEN / 8,
   localparam int OFF_W = $clog2(BE_W)
) (
   input  logic [2:0]       i_funct3,
   input  logic             i_is_store,
   input  logic [OFF_W-1:0] i_off,
   input  logic [XLEN-1:0]  i_sdata,
   input  logic [XLEN-1:0]  i_rdata,
   output logic [BE_W-1:0]  o_be,
   output logic [XLEN-1:0]  o_wdata,
   output logic [XLEN-1:0]  o_ldata,
   output logic             o_misalign,
   output logic             o_illegal
);

   logic [1:0]      w_size;
   logic [BE_W-1:0] w_mask;
   logic [XLEN-1:0] w_shift;

   always_comb begin
      w_size = i_funct3[1:0];

      if (i_is_store)
         o_illegal = i_funct3[2] | ((i_funct3 == F3_SD) && (XLEN == 32));
      else
         o_illegal = (i_funct3 == 3'b111) |
                     ((XLEN == 32) && ((i_funct3 == F3_LD) || (i_funct3 == F3_LWU)));

      case (w_size)
         2'd0:    o_misalign = 1'b0;
         2'd1:    o_misalign = i_off[0];
         2'd2:    o_misalign = (i_off[1:0] != 2'b00);
         default: o_misalign = (i_off != '0);
      endcase

      case (w_size)
         2'd0:    w_mask = BE_W'(1);
         2'd1:    w_mask = BE_W'(3);
         2'd2:    w_mask = BE_W'(15);
         default: w_mask = '1;
      endcase
      o_be = w_mask << i_off;

      // Replicating the datum across the word puts it on every lane the enables can select.
      case (w_size)
         2'd0:    o_wdata = {(BE_W){i_sdata[7:0]}};
         2'd1:    o_wdata = {(BE_W/2){i_sdata[15:0]}};
         2'd2:    o_wdata = {(BE_W/4){i_sdata[31:0]}};
         default: o_wdata = i_sdata;
      endcase

      w_shift = i_rdata >> {i_off, 3'b000};
      case (i_funct3)
         F3_LB:   o_ldata = XLEN'(signed'(w_shift[7:0]));
         F3_LH:   o_ldata = XLEN'(signed'(w_shift[15:0]));
         F3_LW:   o_ldata = XLEN'(signed'(w_shift[31:0]));
         F3_LBU:  o_ldata = XLEN'(w_shift[7:0]);
         F3_LHU:  o_ldata = XLEN'(w_shift[15:0]);
         F3_LWU:  o_ldata = XLEN'(w_shift[31:0]);
         default: o_ldata = w_shift;
      endcase
   end

endmodule

// File: rtl/datam_lsu.sv
// Memory stage between execute and writeback: issues loads/stores over a
// variable-latency req/rsp interface and passes non-memory ops through.
module datam_lsu
   import datam_lsu_pkg::*;
#(
   parameter  int XLEN   = 32,
   parameter  int ADDR_W = 32,
   localparam int BE_W   = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       inst_i,
   input  logic [XLEN-1:0]   r0data_i,
   input  logic [XLEN-1:0]   r1data_i,
   input  logic [XLEN-1:0]   result_i,
   output logic              valid_ro,
   input  logic              ready_i,
   output logic [31:0]       pc_ro,
   output logic [31:0]       inst_ro,
   output logic [XLEN-1:0]   r0data_ro,
   output logic [XLEN-1:0]   r1data_ro,
   output logic [XLEN-1:0]   result_ro,
   output logic [1:0]        exc_ro,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_we,
   output logic [BE_W-1:0]   dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rdata
);

   localparam int OFF_W = $clog2(BE_W);

   state_t           r_state;
   logic [2:0]       r_funct3;
   logic [OFF_W-1:0] r_off;
   logic             r_is_store;
   logic [31:0]      r_pc;
   logic [31:0]      r_inst;
   logic [XLEN-1:0]  r_r0;
   logic [XLEN-1:0]  r_r1;
   logic [XLEN-1:0]  r_addr;

   logic             w_accept;
   logic             w_is_load;
   logic             w_is_store;
   logic             w_is_mem;
   logic             w_idle;
   logic [2:0]       w_funct3;
   logic [OFF_W-1:0] w_off;
   logic             w_sel_store;
   logic [BE_W-1:0]  w_be;
   logic [XLEN-1:0]  w_wdata;
   logic [XLEN-1:0]  w_ldata;
   logic             w_misalign;
   logic             w_illegal;
   logic [1:0]       w_exc;
   logic [ADDR_W-1:0] w_addr;

   assign w_idle     = (r_state == S_IDLE);
   assign ready_o    = w_idle & (~valid_ro | ready_i);
   assign w_accept   = valid_i & ready_o;
   assign w_is_load  = (inst_i[6:0] == OP_LOAD);
   assign w_is_store = (inst_i[6:0] == OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_exc      = exc_code(w_misalign, w_illegal);
   assign w_addr     = {result_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // The aligner decodes the incoming op while idle and the captured op otherwise.
   assign w_funct3    = w_idle ? inst_i[14:12] : r_funct3;
   assign w_off       = w_idle ? result_i[OFF_W-1:0] : r_off;
   assign w_sel_store = w_idle ? w_is_store : r_is_store;

   datam_lsu_align #(.XLEN(XLEN)) u_align (
      .i_funct3   (w_funct3),
      .i_is_store (w_sel_store),
      .i_off      (w_off),
      .i_sdata    (r1data_i),
      .i_rdata    (dmem_rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata),
      .o_misalign (w_misalign),
      .o_illegal  (w_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_funct3       <= '0;
         r_off          <= '0;
         r_is_store     <= 1'b0;
         r_pc           <= '0;
         r_inst         <= '0;
         r_r0           <= '0;
         r_r1           <= '0;
         r_addr         <= '0;
         valid_ro       <= 1'b0;
         pc_ro          <= '0;
         inst_ro        <= '0;
         r0data_ro      <= '0;
         r1data_ro      <= '0;
         result_ro      <= '0;
         exc_ro         <= EXC_NONE;
         dmem_req_valid <= 1'b0;
         dmem_addr      <= '0;
         dmem_we        <= 1'b0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mem && (w_exc == EXC_NONE)) begin
                     r_funct3       <= inst_i[14:12];
                     r_off          <= result_i[OFF_W-1:0];
                     r_is_store     <= w_is_store;
                     r_pc           <= pc_i;
                     r_inst         <= inst_i;
                     r_r0           <= r0data_i;
                     r_r1           <= r1data_i;
                     r_addr         <= result_i;
                     valid_ro       <= 1'b0;
                     dmem_req_valid <= 1'b1;
                     dmem_addr      <= w_addr;
                     dmem_we        <= w_is_store;
                     dmem_be        <= w_be;
                     dmem_wdata     <= w_wdata;
                     r_state        <= S_REQ;
                  end else begin
                     valid_ro  <= 1'b1;
                     pc_ro     <= pc_i;
                     inst_ro   <= inst_i;
                     r0data_ro <= r0data_i;
                     r1data_ro <= r1data_i;
                     result_ro <= result_i;
                     exc_ro    <= w_is_mem ? w_exc : EXC_NONE;
                  end
               end else if (ready_i) begin
                  valid_ro <= 1'b0;
               end
            end
            S_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  r_state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_rsp_valid) begin
                  valid_ro  <= 1'b1;
                  pc_ro     <= r_pc;
                  inst_ro   <= r_inst;
                  r0data_ro <= r_r0;
                  r1data_ro <= r_r1;
                  result_ro <= r_is_store ? r_addr : w_ldata;
                  exc_ro    <= EXC_NONE;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_datam_lsu.sv
// Directed bench for datam_lsu (XLEN=32): passthrough, loads, stores,
// exceptions, downstream stall and reset during an outstanding access.
module tb_datam_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i, ready_o, valid_ro, ready_i;
   logic [31:0] pc_i, inst_i, r0data_i, r1data_i, result_i;
   logic [31:0] pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro;
   logic [1:0]  exc_ro;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] I_ADD = 32'h00B50533;
   localparam logic [31:0] I_LB  = 32'h00050583;
   localparam logic [31:0] I_LH  = 32'h00051583;
   localparam logic [31:0] I_LW  = 32'h00052583;
   localparam logic [31:0] I_LD  = 32'h00053583;
   localparam logic [31:0] I_LBU = 32'h00054583;
   localparam logic [31:0] I_LHU = 32'h00055583;
   localparam logic [31:0] I_SH  = 32'h00B51023;

   always #5 clk = ~clk;

   datam_lsu #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .inst_i(inst_i), .r0data_i(r0data_i), .r1data_i(r1data_i),
      .result_i(result_i),
      .valid_ro(valid_ro), .ready_i(ready_i),
      .pc_ro(pc_ro), .inst_ro(inst_ro), .r0data_ro(r0data_ro), .r1data_ro(r1data_ro),
      .result_ro(result_ro), .exc_ro(exc_ro),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Caller is at a falling edge; drives one instruction for one cycle.
   task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] r1);
      valid_i  = 1'b1;
      inst_i   = inst;
      result_i = addr;
      r1data_i = r1;
      pc_i     = pc_i + 32'd4;
      @(negedge clk);
      valid_i  = 1'b0;
   endtask

   task automatic mem_op(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] r1, input logic [31:0] rd,
                         input int req_stall, input int waits,
                         input logic [3:0] exp_be, input logic exp_we,
                         input logic [31:0] exp_wd, input logic [31:0] exp_res);
      issue(inst, addr, r1);
      chk({tag, "_reqv"},  dmem_req_valid, 1);
      chk({tag, "_addr"},  dmem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "_be"},    dmem_be, exp_be);
      chk({tag, "_we"},    dmem_we, exp_we);
      chk({tag, "_wdata"}, dmem_wdata, exp_wd);
      chk({tag, "_rdy"},   ready_o, 0);
      for (int i = 0; i < req_stall; i++) begin
         @(negedge clk);
         chk({tag, "_hold_v"},  dmem_req_valid, 1);
         chk({tag, "_hold_be"}, dmem_be, exp_be);
         chk({tag, "_hold_wd"}, dmem_wdata, exp_wd);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk({tag, "_reqdrop"}, dmem_req_valid, 0);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk({tag, "_wait_rdy"}, ready_o, 0);
         chk({tag, "_wait_v"},   valid_ro, 0);
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = rd;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      chk({tag, "_vro"}, valid_ro, 1);
      chk({tag, "_res"}, result_ro, exp_res);
      chk({tag, "_exc"}, exc_ro, 0);
      chk({tag, "_inst"}, inst_ro, inst);
      $display("TXN %s addr=%h result=%h", tag, addr, result_ro);
   endtask

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      pc_i = 32'h0000_0100; inst_i = '0; r0data_i = 32'h1111_0000; r1data_i = '0; result_i = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_vro",  valid_ro, 0);
      chk("rst_reqv", dmem_req_valid, 0);
      chk("rst_exc",  exc_ro, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_res",  result_ro, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Passthrough
      chk("add_rdy", ready_o, 1);
      issue(I_ADD, 32'h1234, 32'h0);
      chk("add_vro",  valid_ro, 1);
      chk("add_res",  result_ro, 32'h1234);
      chk("add_exc",  exc_ro, 0);
      chk("add_reqv", dmem_req_valid, 0);
      chk("add_pc",   pc_ro, 32'h0000_0104);
      $display("TXN add result=%h", result_ro);
      @(negedge clk);
      chk("add_drain", valid_ro, 0);

      // Loads with sign/zero extension
      mem_op("lb",  I_LB,  32'h103, 32'h0, 32'h80AABBCC, 0, 2, 4'b1000, 0, 32'h0, 32'hFFFFFF80);
      mem_op("lbu", I_LBU, 32'h103, 32'h0, 32'h80AABBCC, 0, 2, 4'b1000, 0, 32'h0, 32'h00000080);
      mem_op("lh",  I_LH,  32'h102, 32'h0, 32'h80AABBCC, 0, 0, 4'b1100, 0, 32'h0, 32'hFFFF80AA);
      mem_op("lhu", I_LHU, 32'h102, 32'h0, 32'h80AABBCC, 1, 1, 4'b1100, 0, 32'h0, 32'h000080AA);
      mem_op("lw",  I_LW,  32'h104, 32'h0, 32'h12345678, 0, 0, 4'b1111, 0, 32'h0, 32'h12345678);

      // Store with request stall
      mem_op("sh", I_SH, 32'h102, 32'hDEADBEEF, 32'h0, 3, 1, 4'b1100, 1, 32'hBEEFBEEF, 32'h102);

      // Exceptions
      issue(I_LW, 32'h101, 32'h0);
      chk("mis_exc",  exc_ro, 2'b01);
      chk("mis_res",  result_ro, 32'h101);
      chk("mis_vro",  valid_ro, 1);
      chk("mis_reqv", dmem_req_valid, 0);
      $display("TXN lw_misaligned exc=%b", exc_ro);
      issue(I_LD, 32'h200, 32'h0);
      chk("ld_exc",  exc_ro, 2'b10);
      chk("ld_res",  result_ro, 32'h200);
      chk("ld_reqv", dmem_req_valid, 0);
      $display("TXN ld_illegal exc=%b", exc_ro);
      @(negedge clk);

      // Downstream stall
      ready_i = 1'b0;
      issue(I_ADD, 32'h55, 32'h0);
      chk("stl_vro", valid_ro, 1);
      chk("stl_rdy", ready_o, 0);
      valid_i = 1'b1; inst_i = I_ADD; result_i = 32'h66;
      @(negedge clk);
      chk("stl_hold", result_ro, 32'h55);
      chk("stl_rdy2", ready_o, 0);
      ready_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("stl_rel",  result_ro, 32'h66);
      chk("stl_vro2", valid_ro, 1);
      $display("TXN stall_release result=%h", result_ro);
      @(negedge clk);
      chk("stl_drain", valid_ro, 0);

      // Reset while waiting for a response
      issue(I_LW, 32'h300, 32'h0);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("rw_rdy_wait", ready_o, 0);
      rst_n = 1'b0;
      #1;
      chk("rw_reqv", dmem_req_valid, 0);
      chk("rw_vro",  valid_ro, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      chk("rw_late_vro", valid_ro, 0);
      chk("rw_idle_rdy", ready_o, 1);
      chk("rw_res",      result_ro, 0);
      $display("TXN reset_in_wait valid_ro=%b", valid_ro);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
